// File: rtl/l2_arb_pkg.sv
// Shared types for the L1-to-L2 miss arbiter.
// FSM states, client ids and default widths.
package l2_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_client_t;

  function automatic arb_state_t serve_state(
    input arb_client_t c
  );
    return (c == GNT_D) ? SERVE_D : SERVE_I;
  endfunction

endpackage

// File: rtl/l2_arb_select.sv
// Grant choice between I and D requests (combinational).
// in: i_req, d_req, last_grant (ARB_RR_EN only); out: gnt_valid, gnt_client.
module l2_arb_select
  import l2_arb_pkg::*;
(
  input  logic        i_req,
  input  logic        d_req,
`ifdef ARB_RR_EN
  input  arb_client_t last_grant,
`endif
  output logic        gnt_valid,
  output arb_client_t gnt_client
);

  always_comb begin
    gnt_valid  = i_req | d_req;
    gnt_client = GNT_I;
`ifdef ARB_RR_EN
    unique case (1'b1)
      i_req && d_req:
        gnt_client = (last_grant == GNT_I)
                   ? GNT_D : GNT_I;
      d_req && !i_req:
        gnt_client = GNT_D;
      default:
        gnt_client = GNT_I;
    endcase
`else
    if (d_req) begin
      gnt_client = GNT_D;
    end
`endif
  end

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates I/D L1 line misses onto one L2 port; steers resp back.
// Ports: i_*/d_* L1 sides, l2_* upstream side; ARB_RR_EN enables round robin.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  arb_state_t  state;
  arb_state_t  state_d;
  logic        rd_d;
  logic        wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [LINE_W-1:0] wdata_d;

  logic        d_req;
  logic        gnt_valid;
  arb_client_t gnt_client;

`ifdef ARB_RR_EN
  arb_client_t last_grant;
  arb_client_t last_grant_d;
`endif

  assign d_req = d_read | d_write;

  l2_arb_select u_select (
    .i_req      (i_read),
    .d_req      (d_req),
`ifdef ARB_RR_EN
    .last_grant (last_grant),
`endif
    .gnt_valid  (gnt_valid),
    .gnt_client (gnt_client)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
    end else begin
      state      <= state_d;
      l2_read    <= rd_d;
      l2_write   <= wr_d;
      l2_address <= addr_d;
      l2_wdata   <= wdata_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_I;
    end else begin
      last_grant <= last_grant_d;
    end
  end
`endif

  always_comb begin
    state_d = state;
    rd_d    = l2_read;
    wr_d    = l2_write;
    addr_d  = l2_address;
    wdata_d = l2_wdata;
`ifdef ARB_RR_EN
    last_grant_d = last_grant;
`endif
    unique case (state)
      IDLE: begin
        if (gnt_valid) begin
          state_d = serve_state(gnt_client);
          if (gnt_client == GNT_D) begin
            addr_d  = d_address;
            wdata_d = d_wdata;
            // read+write together counts as write
            wr_d    = d_write;
            rd_d    = ~d_write;
          end else begin
            addr_d  = i_address;
            wdata_d = '0;
            wr_d    = 1'b0;
            rd_d    = 1'b1;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
`ifdef ARB_RR_EN
          last_grant_d = (state == SERVE_D)
                       ? GNT_D : GNT_I;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign i_resp  = (state == SERVE_I) & l2_resp;
  assign d_resp  = (state == SERVE_D) & l2_resp;
  assign i_rdata = i_resp ? l2_rdata : '0;
  assign d_rdata = d_resp ? l2_rdata : '0;

endmodule
